// File: rtl/thread_operand_stack_if.sv
// Request/response bundle between decode, the operand stack and the ALU.
interface thread_operand_stack_if #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 256,
    parameter int THREADS = 2
);
    localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic [TW-1:0]      in_tid;
    logic [2:0]         in_op;
    logic [WIDTH-1:0]   in_data;

    logic               out_valid;
    logic [TW-1:0]      out_tid;
    logic [WIDTH-1:0]   out_tos;
    logic [WIDTH-1:0]   out_nos;
    logic [CW-1:0]      out_depth;
    logic               out_err;
    logic [THREADS-1:0] err_flags;

    modport master (
        output in_valid, in_tid, in_op, in_data,
        input  out_valid, out_tid, out_tos, out_nos, out_depth, out_err, err_flags
    );

    modport slave (
        input  in_valid, in_tid, in_op, in_data,
        output out_valid, out_tid, out_tos, out_nos, out_depth, out_err, err_flags
    );
endinterface

// File: rtl/thread_operand_stack.sv
// Per-thread operand stacks with one operation per cycle. Returns the
// pre-operation TOS/NOS and the post-operation depth one cycle later.
// State (counters, storage) is read combinationally from the registers, so
// a request always sees the result of the previous cycle's operation.
// in_tid is expected to be below THREADS.
module thread_operand_stack #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 256,
    parameter int THREADS = 2
) (
    input logic                  clk,
    input logic                  reset,
    thread_operand_stack_if.slave bus
);
    localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = TW + AW;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_DUP   = 3'd3,
        OP_REPL2 = 3'd4,
        OP_REPL1 = 3'd5,
        OP_CLEAR = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    logic [WIDTH-1:0] mem [THREADS*DEPTH];
    logic [CW-1:0]    cnt [THREADS];

    logic [CW-1:0]    cur_cnt;
    logic [CW-1:0]    nxt_cnt;
    logic [AW-1:0]    slot_new;
    logic [AW-1:0]    slot_top;
    logic [AW-1:0]    slot_nos;
    logic [AW-1:0]    wr_slot;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] pre_tos;
    logic [WIDTH-1:0] pre_nos;
    logic [1:0]       need;
    logic             grow;
    logic             wr_en;
    logic             clr;
    logic             err;
    logic             go;
    logic             commit;

    // Decode the operation against the selected thread's current state.
    always_comb begin
        cur_cnt  = cnt[bus.in_tid];
        // Slot arithmetic is modulo DEPTH; a full stack's TOS wraps to DEPTH-1.
        slot_new = cur_cnt[AW-1:0];
        slot_top = slot_new - AW'(1);
        slot_nos = slot_new - AW'(2);
        pre_tos  = (cur_cnt != '0)       ? mem[{bus.in_tid, slot_top}] : '0;
        pre_nos  = (cur_cnt > CW'(1))    ? mem[{bus.in_tid, slot_nos}] : '0;

        need     = 2'd0;
        grow     = 1'b0;
        wr_en    = 1'b0;
        clr      = 1'b0;
        wr_slot  = slot_new;
        wr_data  = bus.in_data;
        nxt_cnt  = cur_cnt;
        case (op_e'(bus.in_op))
            OP_PUSH: begin
                grow    = 1'b1;
                wr_en   = 1'b1;
                nxt_cnt = cur_cnt + CW'(1);
            end
            OP_POP: begin
                need    = 2'd1;
                nxt_cnt = cur_cnt - CW'(1);
            end
            OP_DUP: begin
                need    = 2'd1;
                grow    = 1'b1;
                wr_en   = 1'b1;
                wr_data = pre_tos;
                nxt_cnt = cur_cnt + CW'(1);
            end
            OP_REPL2: begin
                need    = 2'd2;
                wr_en   = 1'b1;
                wr_slot = slot_nos;
                nxt_cnt = cur_cnt - CW'(1);
            end
            OP_REPL1: begin
                need    = 2'd1;
                wr_en   = 1'b1;
                wr_slot = slot_top;
            end
            OP_CLEAR: begin
                clr     = 1'b1;
                nxt_cnt = '0;
            end
            default: ;
        endcase

        err    = (cur_cnt < CW'(need)) || (grow && (cur_cnt == CW'(DEPTH)));
        go     = bus.in_valid && !reset;
        commit = go && !err;
    end

    // Storage is never reset; only committed writes land.
    always_ff @(posedge clk) begin
        if (commit && wr_en)
            mem[{bus.in_tid, wr_slot}] <= wr_data;
    end

    // Per-thread depth counters; rejected ops leave them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < THREADS; t++)
                cnt[t] <= '0;
        end else if (commit) begin
            cnt[bus.in_tid] <= nxt_cnt;
        end
    end

    // Sticky error flags; CLEAR never errors so set and clear cannot collide.
    always_ff @(posedge clk) begin
        if (reset)
            bus.err_flags <= '0;
        else if (go && clr)
            bus.err_flags[bus.in_tid] <= 1'b0;
        else if (go && err)
            bus.err_flags[bus.in_tid] <= 1'b1;
    end

    // Result register; holds its last value while no request is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_tid   <= '0;
            bus.out_tos   <= '0;
            bus.out_nos   <= '0;
            bus.out_depth <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            bus.out_valid <= go;
            if (go) begin
                bus.out_tid   <= bus.in_tid;
                bus.out_tos   <= pre_tos;
                bus.out_nos   <= pre_nos;
                bus.out_depth <= err ? cur_cnt : nxt_cnt;
                bus.out_err   <= err;
            end
        end
    end
endmodule

// File: tb/tb_thread_operand_stack.sv
// Directed, table-driven bench for thread_operand_stack (DEPTH=8, 2 threads).
module tb_thread_operand_stack;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int THREADS = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    thread_operand_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .THREADS(THREADS)) bus ();

    thread_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .THREADS(THREADS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        vld;
        logic        tid;
        logic [2:0]  op;
        logic [15:0] data;
        logic        e_vld;
        logic        e_tid;
        logic [15:0] e_tos;
        logic [15:0] e_nos;
        logic [3:0]  e_depth;
        logic        e_err;
        logic [1:0]  e_flags;
    } vec_t;

    vec_t vq[$];

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                           REPL2 = 3'd4, REPL1 = 3'd5, CLR = 3'd6;

    task automatic add(input logic vld, input logic tid, input logic [2:0] op,
                       input logic [15:0] data, input logic etid,
                       input logic [15:0] tos, input logic [15:0] nos,
                       input int depth, input logic err, input logic [1:0] flags);
        vec_t v;
        v.vld = vld; v.tid = tid; v.op = op; v.data = data;
        v.e_vld = vld; v.e_tid = etid; v.e_tos = tos; v.e_nos = nos;
        v.e_depth = 4'(depth); v.e_err = err; v.e_flags = flags;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic tid, input logic [2:0] op,
                         input logic [15:0] data);
        bus.in_valid = vld;
        bus.in_tid   = tid;
        bus.in_op    = op;
        bus.in_data  = data;
    endtask

    task automatic check_out(input string tag, input logic vld, input logic tid,
                             input logic [15:0] tos, input logic [15:0] nos,
                             input logic [3:0] depth, input logic err,
                             input logic [1:0] flags);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(vld));
        chk({tag, ".tid"},   32'(bus.out_tid),   32'(tid));
        chk({tag, ".tos"},   32'(bus.out_tos),   32'(tos));
        chk({tag, ".nos"},   32'(bus.out_nos),   32'(nos));
        chk({tag, ".depth"}, 32'(bus.out_depth), 32'(depth));
        chk({tag, ".err"},   32'(bus.out_err),   32'(err));
        chk({tag, ".flags"}, 32'(bus.err_flags), 32'(flags));
    endtask

    initial begin
        // Two-entry stack then pop, thread 1 untouched.
        add(1, 0, PUSH,  16'h0011, 0, 16'h0000, 16'h0000, 1, 0, 2'b00);
        add(1, 0, PUSH,  16'h0022, 0, 16'h0011, 16'h0000, 2, 0, 2'b00);
        add(1, 0, POP,   16'h0000, 0, 16'h0022, 16'h0011, 1, 0, 2'b00);
        add(1, 1, NOP,   16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 2'b00);
        // Binary ALU result replacement on thread 1.
        add(1, 1, PUSH,  16'h0003, 1, 16'h0000, 16'h0000, 1, 0, 2'b00);
        add(1, 1, PUSH,  16'h0004, 1, 16'h0003, 16'h0000, 2, 0, 2'b00);
        add(1, 1, REPL2, 16'h0007, 1, 16'h0004, 16'h0003, 1, 0, 2'b00);
        add(1, 1, POP,   16'h0000, 1, 16'h0007, 16'h0000, 0, 0, 2'b00);
        // Drain thread 0, underflow it, then clear the flag.
        add(1, 0, POP,   16'h0000, 0, 16'h0011, 16'h0000, 0, 0, 2'b00);
        add(1, 0, POP,   16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 2'b01);
        add(1, 0, CLR,   16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2'b00);
        // Fill thread 1 to DEPTH with value i.
        for (int i = 0; i < DEPTH; i++)
            add(1, 1, PUSH, 16'(i), 1, (i > 0) ? 16'(i-1) : 16'h0,
                (i > 1) ? 16'(i-2) : 16'h0, i+1, 0, 2'b00);
        add(1, 1, PUSH,  16'h0099, 1, 16'(DEPTH-1), 16'(DEPTH-2), DEPTH,   1, 2'b10);
        add(1, 1, DUP,   16'h0000, 1, 16'(DEPTH-1), 16'(DEPTH-2), DEPTH,   1, 2'b10);
        add(1, 1, POP,   16'h0000, 1, 16'(DEPTH-1), 16'(DEPTH-2), DEPTH-1, 0, 2'b10);
        add(1, 1, CLR,   16'h0000, 1, 16'(DEPTH-2), 16'(DEPTH-3), 0,       0, 2'b00);
        // Interleaved threads every cycle.
        add(1, 0, PUSH,  16'hAAAA, 0, 16'h0000, 16'h0000, 1, 0, 2'b00);
        add(1, 1, PUSH,  16'hBBBB, 1, 16'h0000, 16'h0000, 1, 0, 2'b00);
        add(1, 0, DUP,   16'h0000, 0, 16'hAAAA, 16'h0000, 2, 0, 2'b00);
        add(1, 1, REPL1, 16'hCCCC, 1, 16'hBBBB, 16'h0000, 1, 0, 2'b00);
        add(1, 0, NOP,   16'h0000, 0, 16'hAAAA, 16'hAAAA, 2, 0, 2'b00);
        add(1, 1, 3'd7,  16'h0000, 1, 16'hCCCC, 16'h0000, 1, 0, 2'b00);
        // Idle cycle: out_valid drops, result fields hold.
        add(0, 0, PUSH,  16'h5555, 1, 16'hCCCC, 16'h0000, 1, 0, 2'b00);
        // Thread 0 up to 3 entries ahead of the reset sequence.
        add(1, 0, PUSH,  16'h0033, 0, 16'hAAAA, 16'hAAAA, 3, 0, 2'b00);

        reset = 1'b1;
        drive(0, 0, NOP, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 16'h0, 16'h0, 4'd0, 0, 2'b00);
        reset = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].vld, vq[i].tid, vq[i].op, vq[i].data);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vq[i].e_vld, vq[i].e_tid, vq[i].e_tos,
                      vq[i].e_nos, vq[i].e_depth, vq[i].e_err, vq[i].e_flags);
        end

        // Reset lands together with a PUSH on a 3-deep thread: request dropped.
        reset = 1'b1;
        drive(1, 0, PUSH, 16'h0044);
        @(posedge clk);
        #1;
        check_out("rst_mid", 0, 0, 16'h0, 16'h0, 4'd0, 0, 2'b00);
        reset = 1'b0;
        drive(1, 0, POP, 16'h0);
        @(posedge clk);
        #1;
        check_out("rst_pop", 1, 0, 16'h0, 16'h0, 4'd0, 1, 2'b01);
        drive(1, 1, POP, 16'h0);
        @(posedge clk);
        #1;
        check_out("rst_pop1", 1, 1, 16'h0, 16'h0, 4'd0, 1, 2'b11);
        drive(0, 0, NOP, 16'h0);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
